// File: rtl/cr_tlvp_tx_if.sv
// TLV producer / AXI4-Stream transmit bundle for cr_tlvp_tx.
// Master drives user writes and tready; slave is the transmitter.
interface cr_tlvp_tx_if;
  logic        usr_ob_wr;
  logic [63:0] usr_ob_data;
  logic        usr_ob_sot;
  logic        usr_ob_eot;
  logic        usr_ob_full;
  logic        usr_ob_afull;
  logic        axi4s_ob_tvalid;
  logic        axi4s_ob_tready;
  logic [63:0] axi4s_ob_tdata;
  logic [7:0]  axi4s_ob_tstrb;
  logic [7:0]  axi4s_ob_tuser;
  logic        axi4s_ob_tlast;
  logic        tlvp_tx_error;
  logic [1:0]  tlvp_tx_err_code;
  logic        tlvp_tx_err_clr;

  modport master (
    output usr_ob_wr, usr_ob_data, usr_ob_sot, usr_ob_eot,
    output axi4s_ob_tready, tlvp_tx_err_clr,
    input  usr_ob_full, usr_ob_afull,
    input  axi4s_ob_tvalid, axi4s_ob_tdata, axi4s_ob_tstrb,
    input  axi4s_ob_tuser, axi4s_ob_tlast,
    input  tlvp_tx_error, tlvp_tx_err_code
  );

  modport slave (
    input  usr_ob_wr, usr_ob_data, usr_ob_sot, usr_ob_eot,
    input  axi4s_ob_tready, tlvp_tx_err_clr,
    output usr_ob_full, usr_ob_afull,
    output axi4s_ob_tvalid, axi4s_ob_tdata, axi4s_ob_tstrb,
    output axi4s_ob_tuser, axi4s_ob_tlast,
    output tlvp_tx_error, tlvp_tx_err_code
  );
endinterface

// File: rtl/cr_tlvp_tx.sv
// TLV word FIFO to AXI4-Stream with framing/length checking.
// Beats carry sot/eot in tuser; tlast marks the EOF-type TLV's last word.
module cr_tlvp_tx #(
  parameter int          N_ENTRIES   = 8,
  parameter int          N_AFULL_VAL = 2,
  parameter logic [7:0]  EOF_TYPE    = 8'h09
) (
  input logic         clk,
  input logic         rst,
  cr_tlvp_tx_if.slave bus
);

  localparam int AW = $clog2(N_ENTRIES);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL  = CW'(N_ENTRIES);
  localparam logic [CW-1:0] C_AFULL = CW'(N_ENTRIES - N_AFULL_VAL);

  typedef enum logic {S_IDLE, S_BODY} state_t;

  // entry layout: {data[66:3], sot[2], eot[1], last[0]}
  logic [66:0]   r_mem [N_ENTRIES];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          r_full;
  logic          r_afull;
  state_t        r_state;
  logic [15:0]   r_rem;
  logic [7:0]    r_type;
  logic          r_error;
  logic [1:0]    r_code;

  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic [CW-1:0] w_cnt_nxt;
  logic [66:0]   w_head;
  logic [15:0]   w_len;
  logic [7:0]    w_type;
  logic          w_last;
  logic          w_oerr;
  logic          w_ferr;
  logic          w_lerr;
  logic [1:0]    w_code;
  state_t        w_state_nxt;
  logic [15:0]   w_rem_nxt;

  assign w_valid = (r_cnt != '0);
  assign w_push  = bus.usr_ob_wr & ~r_full;
  assign w_pop   = w_valid & bus.axi4s_ob_tready;
  assign w_oerr  = bus.usr_ob_wr & r_full;
  assign w_head  = r_mem[r_rptr];
  assign w_len   = bus.usr_ob_data[31:16];
  assign w_type  = bus.usr_ob_sot ? bus.usr_ob_data[7:0] : r_type;
  assign w_last  = bus.usr_ob_eot & (w_type == EOF_TYPE);

  always_comb begin
    w_cnt_nxt = r_cnt;
    unique case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 1'b1;
      2'b01:   w_cnt_nxt = r_cnt - 1'b1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_comb begin
    w_ferr      = 1'b0;
    w_lerr      = 1'b0;
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    if (w_push) begin
      if (bus.usr_ob_sot) begin
        if (r_state == S_BODY) w_ferr = 1'b1;
        if (w_len == '0) w_lerr = 1'b1;
        if (bus.usr_ob_eot) begin
          if (w_len != 16'd1) w_lerr = 1'b1;
          w_state_nxt = S_IDLE;
          w_rem_nxt   = '0;
        end else begin
          w_state_nxt = S_BODY;
          w_rem_nxt   = (w_len == '0) ? '0 : w_len - 16'd1;
        end
      end else if (r_state == S_IDLE) begin
        w_ferr = 1'b1;
      end else if (bus.usr_ob_eot) begin
        if (r_rem != 16'd1) w_lerr = 1'b1;
        w_state_nxt = S_IDLE;
        w_rem_nxt   = '0;
      end else if (r_rem == '0) begin
        w_lerr = 1'b1;
      end else begin
        w_rem_nxt = r_rem - 16'd1;
      end
    end
  end

  // lowest code wins when several fire together
  always_comb begin
    w_code = 2'd0;
    if (w_oerr)      w_code = 2'd1;
    else if (w_ferr) w_code = 2'd2;
    else if (w_lerr) w_code = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= {bus.usr_ob_data, bus.usr_ob_sot,
                        bus.usr_ob_eot, w_last};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == C_FULL);
      r_afull <= (w_cnt_nxt >= C_AFULL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_type  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      if (w_push & bus.usr_ob_sot) r_type <= bus.usr_ob_data[7:0];
    end
  end

  // a new error beats a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_error <= 1'b0;
      r_code  <= '0;
    end else if (w_code != 2'd0) begin
      if (!r_error || bus.tlvp_tx_err_clr) begin
        r_error <= 1'b1;
        r_code  <= w_code;
      end
    end else if (bus.tlvp_tx_err_clr) begin
      r_error <= 1'b0;
      r_code  <= '0;
    end
  end

  assign bus.usr_ob_full      = r_full;
  assign bus.usr_ob_afull     = r_afull;
  assign bus.axi4s_ob_tvalid  = w_valid;
  assign bus.axi4s_ob_tdata   = w_valid ? w_head[66:3] : '0;
  assign bus.axi4s_ob_tstrb   = 8'hff;
  assign bus.axi4s_ob_tuser   = w_valid ? {6'b0, w_head[1], w_head[2]} : '0;
  assign bus.axi4s_ob_tlast   = w_valid & w_head[0];
  assign bus.tlvp_tx_error    = r_error;
  assign bus.tlvp_tx_err_code = r_code;

endmodule

// File: tb/tb_cr_tlvp_tx.sv
// Directed bench for cr_tlvp_tx: framing, flow control, errors, reset.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_cr_tlvp_tx;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_mis = 0;
  logic [63:0] exp_q [8];

  cr_tlvp_tx_if bus();

  cr_tlvp_tx #(
    .N_ENTRIES(8),
    .N_AFULL_VAL(2),
    .EOF_TYPE(8'h09)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [63:0] d, input logic s, input logic e);
    bus.usr_ob_wr   = 1'b1;
    bus.usr_ob_data = d;
    bus.usr_ob_sot  = s;
    bus.usr_ob_eot  = e;
  endtask

  task automatic idle();
    bus.usr_ob_wr   = 1'b0;
    bus.usr_ob_data = '0;
    bus.usr_ob_sot  = 1'b0;
    bus.usr_ob_eot  = 1'b0;
  endtask

  task automatic chk_beat(input string tag, input logic [63:0] d,
                          input logic [7:0] u, input logic l);
    chk({tag, "_tvalid"}, 64'(bus.axi4s_ob_tvalid), 64'd1);
    chk({tag, "_tdata"}, bus.axi4s_ob_tdata, d);
    chk({tag, "_tuser"}, 64'(bus.axi4s_ob_tuser), 64'(u));
    chk({tag, "_tlast"}, 64'(bus.axi4s_ob_tlast), 64'(l));
  endtask

  task automatic chk_err(input string tag, input logic e,
                         input logic [1:0] c);
    chk({tag, "_error"}, 64'(bus.tlvp_tx_error), 64'(e));
    chk({tag, "_code"}, 64'(bus.tlvp_tx_err_code), 64'(c));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus.axi4s_ob_tready = 1'b0;
    bus.tlvp_tx_err_clr = 1'b0;
    step();
    step();
    chk("rst_tvalid", 64'(bus.axi4s_ob_tvalid), 64'd0);
    chk("rst_tdata", bus.axi4s_ob_tdata, 64'd0);
    chk("rst_tuser", 64'(bus.axi4s_ob_tuser), 64'd0);
    chk("rst_tlast", 64'(bus.axi4s_ob_tlast), 64'd0);
    chk("rst_tstrb", 64'(bus.axi4s_ob_tstrb), 64'hff);
    chk("rst_full", 64'(bus.usr_ob_full), 64'd0);
    chk("rst_afull", 64'(bus.usr_ob_afull), 64'd0);
    chk_err("rst", 1'b0, 2'd0);
    rst = 1'b0;
    step();

    // 3-word EOF TLV streaming with tready=1
    bus.axi4s_ob_tready = 1'b1;
    put(64'h0000_0000_0003_0009, 1'b1, 1'b0);
    step();
    chk_beat("t1_b0", 64'h0000_0000_0003_0009, 8'h01, 1'b0);
    put(64'hAAAA_0000_1111_0000, 1'b0, 1'b0);
    step();
    chk_beat("t1_b1", 64'hAAAA_0000_1111_0000, 8'h00, 1'b0);
    put(64'hBBBB_0000_2222_0000, 1'b0, 1'b1);
    step();
    chk_beat("t1_b2", 64'hBBBB_0000_2222_0000, 8'h02, 1'b1);
    idle();
    step();
    chk("t1_drain", 64'(bus.axi4s_ob_tvalid), 64'd0);
    chk_err("t1", 1'b0, 2'd0);

    // fill with tready=0, then overflow
    bus.axi4s_ob_tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_q[i] = (i == 0) ? 64'h0000_0000_0008_0009
                          : 64'h0000_0000_0000_1000 + 64'(i);
      put(exp_q[i], i == 0, i == 7);
      step();
      if (i == 4) chk("t2_afull5", 64'(bus.usr_ob_afull), 64'd0);
      if (i == 5) chk("t2_afull6", 64'(bus.usr_ob_afull), 64'd1);
      if (i == 6) chk("t2_full7", 64'(bus.usr_ob_full), 64'd0);
    end
    chk("t2_full8", 64'(bus.usr_ob_full), 64'd1);
    chk_err("t2_pre", 1'b0, 2'd0);
    put(64'h0000_0000_0000_DEAD, 1'b0, 1'b0);
    step();
    chk_err("t2_ovf", 1'b1, 2'd1);
    idle();
    step();
    chk_beat("t2_hold", exp_q[0], 8'h01, 1'b0);
    bus.axi4s_ob_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk_beat($sformatf("t2_b%0d", i), exp_q[i],
               (i == 0) ? 8'h01 : (i == 7) ? 8'h02 : 8'h00, i == 7);
      step();
      if (i == 0) chk("t2_unfull", 64'(bus.usr_ob_full), 64'd0);
    end
    chk("t2_drain", 64'(bus.axi4s_ob_tvalid), 64'd0);
    bus.tlvp_tx_err_clr = 1'b1;
    step();
    bus.tlvp_tx_err_clr = 1'b0;
    chk_err("t2_clr", 1'b0, 2'd0);

    // length 4 with early eot
    put(64'h0000_0000_0004_0009, 1'b1, 1'b0);
    step();
    chk_beat("t3_b0", 64'h0000_0000_0004_0009, 8'h01, 1'b0);
    chk_err("t3_ok", 1'b0, 2'd0);
    put(64'h0000_0000_0000_00CC, 1'b0, 1'b1);
    step();
    chk_beat("t3_b1", 64'h0000_0000_0000_00CC, 8'h02, 1'b1);
    chk_err("t3_len", 1'b1, 2'd3);
    idle();
    bus.tlvp_tx_err_clr = 1'b1;
    step();
    bus.tlvp_tx_err_clr = 1'b0;
    chk_err("t3_clr", 1'b0, 2'd0);

    // single-word TLVs; sot accepted cleanly proves IDLE
    put(64'h0000_0000_0001_0001, 1'b1, 1'b1);
    step();
    chk_beat("t4_b0", 64'h0000_0000_0001_0001, 8'h03, 1'b0);
    chk_err("t4_a", 1'b0, 2'd0);
    put(64'h0000_0000_0001_0009, 1'b1, 1'b1);
    step();
    chk_beat("t4_b1", 64'h0000_0000_0001_0009, 8'h03, 1'b1);
    chk_err("t4_b", 1'b0, 2'd0);
    put(64'h0000_0000_0002_0001, 1'b1, 1'b1);
    step();
    chk_err("t4_len", 1'b1, 2'd3);
    put(64'h0000_0000_0000_0077, 1'b0, 1'b1);
    step();
    chk_err("t4_keep", 1'b1, 2'd3);
    put(64'h0000_0000_0000_0078, 1'b0, 1'b0);
    bus.tlvp_tx_err_clr = 1'b1;
    step();
    chk_err("t4_clrwin", 1'b1, 2'd2);
    idle();
    step();
    chk_err("t4_clr", 1'b0, 2'd0);
    bus.tlvp_tx_err_clr = 1'b0;

    // non-sot first word after reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    put(64'h0000_0000_0000_0055, 1'b0, 1'b0);
    step();
    chk_beat("t5_b0", 64'h0000_0000_0000_0055, 8'h00, 1'b0);
    chk_err("t5", 1'b1, 2'd2);
    idle();
    bus.tlvp_tx_err_clr = 1'b1;
    step();
    bus.tlvp_tx_err_clr = 1'b0;
    chk_err("t5_clr", 1'b0, 2'd0);

    // reset mid-TLV with 3 words buffered
    bus.axi4s_ob_tready = 1'b0;
    put(64'h0000_0000_0005_0009, 1'b1, 1'b0);
    step();
    put(64'h0000_0000_0000_0101, 1'b0, 1'b0);
    step();
    put(64'h0000_0000_0000_0102, 1'b0, 1'b0);
    step();
    idle();
    chk("t6_pre", 64'(bus.axi4s_ob_tvalid), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_async", 64'(bus.axi4s_ob_tvalid), 64'd0);
    step();
    rst = 1'b0;
    bus.axi4s_ob_tready = 1'b1;
    step();
    chk("t6_empty", 64'(bus.axi4s_ob_tvalid), 64'd0);
    chk("t6_afull", 64'(bus.usr_ob_afull), 64'd0);
    put(64'h0000_0000_0001_0009, 1'b1, 1'b1);
    step();
    chk_beat("t6_b0", 64'h0000_0000_0001_0009, 8'h03, 1'b1);
    chk_err("t6", 1'b0, 2'd0);
    idle();
    step();
    chk("t6_drain", 64'(bus.axi4s_ob_tvalid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/cr_tlvp_tx.md
CR_TLVP_TX -- requirements
Module: cr_tlvp_tx

Interface
REQ-001 The block SHALL have parameter N_ENTRIES, default 8: output FIFO depth in 64-bit words, power of 2, minimum 4.
REQ-002 The block SHALL have parameter N_AFULL_VAL, default 2: usr_ob_afull asserts when count >= N_ENTRIES-N_AFULL_VAL.
REQ-003 The block SHALL have parameter EOF_TYPE, default 8'h09: TLV type that terminates a frame.
REQ-004 The block SHALL have a single clock and an asynchronous, active-high reset, with these ports (name direction width meaning):
- clk in 1: single clock; all logic on the rising edge.
- rst in 1: asynchronous, active-high reset.
- usr_ob_wr in 1: write strobe for one TLV word.
- usr_ob_data in 64: TLV word; on an sot word, [7:0]=type and [31:16]=length in words, header included.
- usr_ob_sot in 1: word is the first word of a TLV.
- usr_ob_eot in 1: word is the last word of a TLV.
- usr_ob_full out 1: FIFO count == N_ENTRIES.
- usr_ob_afull out 1: almost full (REQ-002).
- axi4s_ob_tvalid out 1: AXI4-Stream beat valid.
- axi4s_ob_tready in 1: downstream ready.
- axi4s_ob_tdata out 64: beat data.
- axi4s_ob_tstrb out 8: constant 8'hff.
- axi4s_ob_tuser out 8: [0]=sot, [1]=eot, [7:2]=0.
- axi4s_ob_tlast out 1: last beat of a frame.
- tlvp_tx_error out 1: sticky error flag.
- tlvp_tx_err_code out 2: first error code captured; 1=overflow, 2=framing, 3=length.
- tlvp_tx_err_clr in 1: clears the error flag and code.

Function
REQ-005 A write SHALL be accepted when usr_ob_wr=1 and usr_ob_full=0; full SHALL use the registered count, so a same-cycle pop does not admit a write when full.
REQ-006 A write with usr_ob_full=1 SHALL drop the word and raise error code 1.
REQ-007 An accepted word SHALL be stored with {data, sot, eot, last}, where last = eot AND (latched TLV type == EOF_TYPE).
- For a word with sot=1, the type is taken from the word itself.
REQ-008 Latency SHALL be 1 cycle: a word written into an empty FIFO in cycle N drives axi4s_ob_tvalid=1 in cycle N+1.
REQ-009 A beat SHALL pop on tvalid AND tready.
- While tvalid=1 and tready=0, tdata, tuser and tlast SHALL hold stable.
- tvalid SHALL NOT deassert without a pop.
REQ-010 Simultaneous push and pop SHALL leave the count unchanged; read and write pointers SHALL wrap modulo N_ENTRIES.
REQ-011 The framing FSM SHALL have states IDLE (awaiting sot) and BODY; it updates on accepted writes only.
REQ-012 FSM transitions SHALL be as follows.
- IDLE + sot + eot: stays IDLE.
- IDLE + sot + !eot: goes to BODY and loads remaining = length-1.
- BODY + !sot + !eot: remaining decrements, saturating at 0.
- BODY + eot: goes to IDLE.
REQ-013 Framing errors (code 2) SHALL be raised as follows.
- sot in BODY: the FSM restarts the TLV and reloads remaining.
- non-sot word in IDLE: the FSM stays in IDLE.
- In both cases the word is still stored.
REQ-014 Length errors (code 3) SHALL be raised as follows.
- length==0 on an sot word.
- eot when remaining != 1 (BODY) or length != 1 (sot+eot word).
- a non-eot word written when remaining==0.
- The word is still stored.
REQ-015 Error capture rules.
- tlvp_tx_error SHALL set on the first error and stay set.
- tlvp_tx_err_code SHALL hold the first code; later errors do not overwrite it.
- If errors are simultaneous, the lowest code SHALL win.
- tlvp_tx_err_clr SHALL clear both next cycle; an error in the same cycle as clr SHALL win.
REQ-016 usr_ob_full and usr_ob_afull SHALL be registered, derived from the next-cycle count.

Reset
REQ-017 While rst=1, the block SHALL be in this state:
- axi4s_ob_tvalid=0, tdata=0, tuser=0, tlast=0, tstrb=8'hff;
- usr_ob_full=0, usr_ob_afull=0;
- tlvp_tx_error=0, tlvp_tx_err_code=0;
- FSM=IDLE, count=0, pointers=0.
REQ-018 Reset asserted mid-TLV SHALL discard all FIFO contents and partial TLV state; the first post-reset word must carry sot or a framing error is raised.

Verification
REQ-019 The bench SHALL cover a 3-word TLV (type 8'h09, length 3) with tready=1: beats appear on cycles N+1..N+3, tuser = 01, 00, 02, tlast=1 only on beat 3, no error.
REQ-020 The bench SHALL cover tready=0 while 8 words are written: usr_ob_full=1 after the 8th write and usr_ob_afull=1 after the 6th; a 9th write is dropped with error=1, code=1; on releasing tready, exactly 8 beats are output in order.
REQ-021 The bench SHALL cover a TLV with length 4 and eot on word 2: code=3, both words output, FSM back in IDLE.
REQ-022 The bench SHALL cover a non-sot first word after reset: code=2, the word is still output with tuser=00.
REQ-023 The bench SHALL cover a single-word TLV (sot+eot, length 1, type 8'h01) followed by a single-word TLV (sot+eot, length 1, type 8'h09): tlast is 0 then 1, no error; a later code-3 error does not overwrite the latched code until err_clr.
REQ-024 The bench SHALL cover rst pulsed mid-TLV with 3 words buffered: tvalid=0 next cycle, count=0, and a clean TLV afterwards passes with no error.
